// File: rtl/charlieplex_pkg.sv
// charlieplex_pkg: shared constants, event types, scanner states and the row/col to pin mapping
package charlieplex_pkg;
  localparam int NUM_PINS = 6;
  localparam int NUM_COLS = 5;
  localparam int NUM_KEYS = 30;
  typedef logic [4:0] key_code_t;
  typedef struct packed {
    logic      is_release;
    key_code_t code;
  } key_event_t;
  typedef enum logic [1:0] {DRIVE, SAMPLE, EMIT} scan_state_t;
  function automatic logic [2:0] pin_of(input logic [2:0] row, input logic [2:0] col);
    return (col < row) ? col : col + 3'd1;
  endfunction
endpackage

// File: rtl/charlieplex_key_scanner_event_fifo.sv
// event_fifo: small synchronous key-event FIFO that reports pushes it had to drop when full
module event_fifo
  import charlieplex_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       ready,
  output logic       valid,
  output key_event_t head,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);
  key_event_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_pop, do_push;
  assign valid = cnt != '0;
  assign do_pop = valid && ready;
  assign do_push = push && (cnt != (AW+1)'(DEPTH) || do_pop);
  assign drop = push && !do_push;
  assign head = valid ? mem[rd] : '0;
  // pointer and occupancy bookkeeping; a pop frees room for a same-cycle push when full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= (wr == AW'(DEPTH-1)) ? '0 : wr + 1'b1;
      if (do_pop) rd <= (rd == AW'(DEPTH-1)) ? '0 : rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; head is masked while empty
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= push_data;
endmodule

// File: rtl/charlieplex_key_scanner.sv
// charlieplex_key_scanner: scans a 30-key charlieplexed keypad, debounces, queues press events (release events with KEYSCAN_RELEASE_EVENTS_EN)
module charlieplex_key_scanner
  import charlieplex_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] pins_in,
  output logic [NUM_PINS-1:0] pins_out,
  output logic [NUM_PINS-1:0] pins_oe,
  output logic [NUM_KEYS-1:0] keys,
  output logic                evt_valid,
  output logic [4:0]          evt_code,
  output logic                evt_release,
  input  logic                evt_ready,
  output logic                overflow
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  logic [NUM_PINS-1:0] sync1, sync2;
  logic run, push, drop;
  scan_state_t state, state_nxt;
  logic [2:0] row, col;
  logic [SW-1:0] settle;
  logic [NUM_KEYS-1:0][DW-1:0] dcnt;
  logic [NUM_COLS-1:0] raw, cur, hit, flip;
  logic [NUM_COLS-1:0][DW-1:0] cnt;
  key_code_t base, code;
  key_event_t ev, head;
  assign pins_oe = run ? NUM_PINS'(1) << row : '0;
  assign pins_out = pins_oe;
  assign base = {2'b0, row} * 5'd5;
  assign code = base + {2'b0, col};
  assign ev.code = code;
`ifdef KEYSCAN_RELEASE_EVENTS_EN
  assign ev.is_release = ~keys[code];
  assign push = state == EMIT && flip[col];
`else
  assign ev.is_release = 1'b0;
  assign push = state == EMIT && flip[col] && keys[code];
`endif
  assign evt_code = head.code;
  assign evt_release = head.is_release;
  // two-flop synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk or posedge rst)
    if (rst) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, pins_in};
  // slot sequencing: settle in DRIVE, one SAMPLE, then one EMIT per column
  always_comb begin
    state_nxt = state;
    state_nxt = !run ? DRIVE
              : state == DRIVE ? (settle == SW'(SETTLE_CYCLES - 1) ? SAMPLE : DRIVE)
              : state == SAMPLE ? EMIT
              : col == 3'd4 ? DRIVE : EMIT;
  end
  // state register plus row/col/settle counters and the sticky overflow flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run <= 1'b0;
      state <= DRIVE;
      row <= '0;
      col <= '0;
      settle <= '0;
      overflow <= 1'b0;
    end else begin
      run <= 1'b1;
      state <= state_nxt;
      settle <= (run && state == DRIVE && state_nxt == DRIVE) ? settle + 1'b1 : '0;
      col <= state == EMIT ? col + 3'd1 : '0;
      if (state == EMIT && col == 3'd4) row <= row == 3'd5 ? '0 : row + 3'd1;
      overflow <= overflow | drop;
    end
  // gather the current row's sense bits and debounce status by column
  always_comb begin
    raw = '0;
    cur = '0;
    cnt = '0;
    hit = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      raw[c] = sync2[pin_of(row, 3'(c))];
      cur[c] = keys[base + 5'(c)];
      cnt[c] = dcnt[base + 5'(c)];
      hit[c] = raw[c] != cur[c] && cnt[c] == DW'(DEBOUNCE - 1);
    end
  end
  // per-key debounce update for the sampled row; flips are remembered for EMIT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      keys <= '0;
      dcnt <= '0;
      flip <= '0;
    end else if (state == SAMPLE)
      for (int c = 0; c < NUM_COLS; c++) begin
        flip[c] <= hit[c];
        keys[base + 5'(c)] <= cur[c] ^ hit[c];
        dcnt[base + 5'(c)] <= (raw[c] == cur[c] || hit[c]) ? '0 : cnt[c] + 1'b1;
      end
  event_fifo #(.DEPTH(4)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(ev),
    .ready(evt_ready),
    .valid(evt_valid),
    .head(head),
    .drop(drop)
  );
endmodule
